// File: rtl/seg_scan2.sv
// rtl/seg_scan2.sv - two-digit multiplexed 7-segment scan driver
// Inputs are latched once per frame; each digit slot opens with a blank window against ghosting.
module seg_scan2 #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16,
   parameter bit SEG_INV   = 1'b0,
   parameter bit LZ_BLANK  = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] hex0,
   input  logic [3:0] hex1,
   input  logic [1:0] dp,
   input  logic [1:0] en,
   output logic [1:0] com,
   output logic [7:0] seg,
   output logic       frame
);

   localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   localparam logic [7:0]    SEG_OFF   = {8{SEG_INV}};

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic [3:0]    hex0_sh_q, hex0_sh_d;
   logic [3:0]    hex1_sh_q, hex1_sh_d;
   logic [1:0]    dp_sh_q, dp_sh_d;
   logic [1:0]    en_sh_q, en_sh_d;
   logic          ld_first_q, ld_first_d;
   logic          frame_q, frame_d;
   logic [1:0]    com_q, com_d;
   logic [7:0]    seg_q, seg_d;

   logic          tick;
   logic          load;
   logic [3:0]    hex_cur;
   logic          dp_cur;
   logic          en_cur;
   logic          blank;
   logic          lz_sup;
   logic [7:0]    seg_raw;

   function automatic logic [6:0] decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Slot timing and frame-start shadow load (frame start is the sel 1->0 switch)
   always_comb begin
      tick       = (cnt_q == CNT_MAX);
      load       = ld_first_q | (tick & sel_q);
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      sel_d      = tick ? ~sel_q : sel_q;
      hex0_sh_d  = load ? hex0 : hex0_sh_q;
      hex1_sh_d  = load ? hex1 : hex1_sh_q;
      dp_sh_d    = load ? dp   : dp_sh_q;
      en_sh_d    = load ? en   : en_sh_q;
      ld_first_d = load ? 1'b0 : ld_first_q;
      frame_d    = load;
   end

   // Output selection from the current (pre-edge) slot state and shadow
   always_comb begin
      hex_cur = sel_q ? hex1_sh_q : hex0_sh_q;
      dp_cur  = sel_q ? dp_sh_q[1] : dp_sh_q[0];
      en_cur  = sel_q ? en_sh_q[1] : en_sh_q[0];
      blank   = (cnt_q < BLANK_END);
      lz_sup  = LZ_BLANK && sel_q && (hex1_sh_q == 4'h0);
      com_d   = 2'b11;
      seg_raw = 8'h00;
      if (!blank && en_cur) begin
         com_d   = sel_q ? 2'b01 : 2'b10;
         seg_raw = {dp_cur, lz_sup ? 7'h00 : decode(hex_cur)};
      end
      seg_d = seg_raw ^ SEG_OFF;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         hex0_sh_q  <= 4'h0;
         hex1_sh_q  <= 4'h0;
         dp_sh_q    <= 2'b00;
         en_sh_q    <= 2'b00;
         ld_first_q <= 1'b1;
         frame_q    <= 1'b0;
         com_q      <= 2'b11;
         seg_q      <= SEG_OFF;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         hex0_sh_q  <= hex0_sh_d;
         hex1_sh_q  <= hex1_sh_d;
         dp_sh_q    <= dp_sh_d;
         en_sh_q    <= en_sh_d;
         ld_first_q <= ld_first_d;
         frame_q    <= frame_d;
         com_q      <= com_d;
         seg_q      <= seg_d;
      end
   end

   assign com   = com_q;
   assign seg   = seg_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan2.sv
// tb/tb_seg_scan2.sv - bench for seg_scan2
// Three instances share stimulus: default, LZ_BLANK=0 and SEG_INV=1.
module tb_seg_scan2;

   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRM   = 2 * DIV;
   localparam int NVEC  = 13;

   typedef struct packed {
      logic [3:0] h0;
      logic [3:0] h1;
      logic [1:0] dp;
      logic [1:0] en;
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] s1n;
   } vec_t;

   typedef struct packed {
      logic [1:0] com;
      logic [7:0] seg;
      logic [7:0] segn;
      logic       frame;
   } exp_t;

   logic       sys_clk;
   logic       sys_rst;
   logic [3:0] hex0, hex1;
   logic [1:0] dp, en;
   logic [1:0] com_a, com_b, com_c;
   logic [7:0] seg_a, seg_b, seg_c;
   logic       frame_a, frame_b, frame_c;

   vec_t vec [NVEC];
   exp_t sb[$];
   int   cur_idx;
   int   act_idx;
   bit   sh_valid;
   int   k;
   int   n_pass;
   int   n_total;

   seg_scan2 #(.CLK_DIV(DIV), .BLANK_CYC(BLK), .SEG_INV(1'b0), .LZ_BLANK(1'b1)) u_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .hex0(hex0), .hex1(hex1), .dp(dp), .en(en),
      .com(com_a), .seg(seg_a), .frame(frame_a));

   seg_scan2 #(.CLK_DIV(DIV), .BLANK_CYC(BLK), .SEG_INV(1'b0), .LZ_BLANK(1'b0)) u_b (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .hex0(hex0), .hex1(hex1), .dp(dp), .en(en),
      .com(com_b), .seg(seg_b), .frame(frame_b));

   seg_scan2 #(.CLK_DIV(DIV), .BLANK_CYC(BLK), .SEG_INV(1'b1), .LZ_BLANK(1'b1)) u_c (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .hex0(hex0), .hex1(hex1), .dp(dp), .en(en),
      .com(com_c), .seg(seg_c), .frame(frame_c));

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s k=%0d: got %h, required %h", name, k, act, req);
   endtask

   task automatic drive();
      hex0 = vec[cur_idx].h0;
      hex1 = vec[cur_idx].h1;
      dp   = vec[cur_idx].dp;
      en   = vec[cur_idx].en;
   endtask

   // Expected outputs after edge k, i.e. for scan position k-1 counted from reset release
   function automatic exp_t model(input int kk);
      exp_t e;
      vec_t v;
      int   p, sel, off;
      logic [1:0] en_sh;
      p     = kk - 1;
      sel   = (p / DIV) % 2;
      off   = p % DIV;
      v     = vec[act_idx];
      en_sh = sh_valid ? v.en : 2'b00;
      e.com   = 2'b11;
      e.seg   = 8'h00;
      e.segn  = 8'h00;
      e.frame = (kk == 1) || (kk % FRM == 0);
      if (off >= BLK && en_sh[sel]) begin
         e.com  = (sel == 1) ? 2'b01 : 2'b10;
         e.seg  = (sel == 1) ? v.s1  : v.s0;
         e.segn = (sel == 1) ? v.s1n : v.s0;
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      @(posedge sys_clk);
      if (sys_rst) begin
         e = '{com: 2'b11, seg: 8'h00, segn: 8'h00, frame: 1'b0};
      end else begin
         k++;
         e = model(k);
         if (k == 1 || k % FRM == 0) begin
            act_idx  = cur_idx;
            sh_valid = 1'b1;
         end
      end
      sb.push_back(e);
      @(negedge sys_clk);
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty k=%0d: got 0 entries, required 1", k);
      end else begin
         e = sb.pop_front();
         chk("com_a",   {6'd0, com_a},   {6'd0, e.com});
         chk("seg_a",   seg_a,           e.seg);
         chk("frame_a", {7'd0, frame_a}, {7'd0, e.frame});
         chk("com_b",   {6'd0, com_b},   {6'd0, e.com});
         chk("seg_b",   seg_b,           e.segn);
         chk("frame_b", {7'd0, frame_b}, {7'd0, e.frame});
         chk("com_c",   {6'd0, com_c},   {6'd0, e.com});
         chk("seg_c",   seg_c,           ~e.seg);
         chk("frame_c", {7'd0, frame_c}, {7'd0, e.frame});
      end
   endtask

   initial begin
      bit found;
      //          h0    h1    dp     en     s0     s1     s1n
      vec[0]  = '{4'h7, 4'h4, 2'b00, 2'b11, 8'h07, 8'h66, 8'h66};
      vec[1]  = '{4'h3, 4'h4, 2'b00, 2'b11, 8'h4F, 8'h66, 8'h66};
      vec[2]  = '{4'h3, 4'h0, 2'b10, 2'b11, 8'h4F, 8'h80, 8'hBF};
      vec[3]  = '{4'h8, 4'h0, 2'b00, 2'b01, 8'h7F, 8'h00, 8'h00};
      vec[4]  = '{4'h8, 4'hA, 2'b01, 2'b11, 8'hFF, 8'h77, 8'h77};
      vec[5]  = '{4'hF, 4'hB, 2'b11, 2'b10, 8'h00, 8'hFC, 8'hFC};
      vec[6]  = '{4'h5, 4'h1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00};
      vec[7]  = '{4'h2, 4'h9, 2'b00, 2'b11, 8'h5B, 8'h6F, 8'h6F};
      vec[8]  = '{4'hC, 4'hD, 2'b00, 2'b11, 8'h39, 8'h5E, 8'h5E};
      vec[9]  = '{4'hE, 4'h6, 2'b00, 2'b11, 8'h79, 8'h7D, 8'h7D};
      vec[10] = '{4'h0, 4'h0, 2'b00, 2'b11, 8'h3F, 8'h00, 8'h3F};
      vec[11] = '{4'h5, 4'h1, 2'b00, 2'b11, 8'h6D, 8'h06, 8'h06};
      vec[12] = '{4'hF, 4'hF, 2'b00, 2'b01, 8'h71, 8'h00, 8'h00};

      n_pass   = 0;
      n_total  = 0;
      k        = 0;
      act_idx  = 0;
      sh_valid = 1'b0;
      cur_idx  = 0;
      sys_rst  = 1'b1;
      drive();

      repeat (3) step();
      sys_rst = 1'b0;

      // One frame per vector; inputs change mid-frame (alternating digit0/digit1 slot)
      for (int f = 0; f < NVEC; f++) begin
         for (int pos = 1; pos <= FRM; pos++) begin
            step();
            if (f < NVEC - 1 && pos == ((f % 2 == 1) ? 5 : 12)) begin
               cur_idx = f + 1;
               drive();
            end
         end
      end

      cur_idx = 0;
      drive();
      found = 1'b0;
      for (int i = 0; i < 4 * FRM && !found; i++) begin
         step();
         if (com_a == 2'b01) found = 1'b1;
      end
      n_total++;
      if (found) n_pass++;
      else $display("FAIL wait_com01: got com=%b, required 01 within %0d cycles", com_a, 4 * FRM);

      // Asynchronous reset between edges while digit1 is lit
      #2 sys_rst = 1'b1;
      k        = 0;
      sh_valid = 1'b0;
      #1;
      chk("async_com_a", {6'd0, com_a}, 8'h03);
      chk("async_seg_a", seg_a, 8'h00);
      chk("async_com_b", {6'd0, com_b}, 8'h03);
      chk("async_seg_c", seg_c, 8'hFF);
      chk("async_frame", {7'd0, frame_a}, 8'h00);

      repeat (2) step();
      sys_rst = 1'b0;
      repeat (2 * FRM + 4) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg_scan2.md
Name: seg_scan2

Overview:
- Two-digit multiplexed 7-segment scan driver that sits directly downstream of the counter/control logic in the board top level.
- Accepts two hex nibbles plus per-digit decimal-point and enable bits.
- Latches them once per scan frame (tear-free) and time-multiplexes them onto the shared `seg[7:0]` bus and the `com[1:0]` digit selects.
- Inserts a ghost-suppression blank window at every digit switch.

Parameters:
- CLK_DIV, 50000, clocks per digit slot (>= 4).
- BLANK_CYC, 16, clocks at the start of each slot with both commons off (1 <= BLANK_CYC < CLK_DIV).
- SEG_INV, 0, 1 = segment outputs active-low; 0 = active-high.
- LZ_BLANK, 1, 1 = suppress a-g of digit1 when its value is 0.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- hex0  in  4  value for digit0 (right)
- hex1  in  4  value for digit1 (left)
- dp  in  2  decimal point per digit, bit i -> digit i
- en  in  2  digit enable, bit i -> digit i
- com  out  2  digit commons, active-low; com[0] -> digit0, com[1] -> digit1
- seg  out  8  seg[0]=a .. seg[6]=g, seg[7]=dp
- frame  out  1  one-clock pulse when the shadow registers load

Behaviour:
- Reset (async, sys_rst=1):
  - cnt=0, sel=0, shadow hex/dp/en=0, ld_first=1.
  - com=2'b11; seg=8'h00 (SEG_INV=0) or 8'hFF (SEG_INV=1); frame=0.
  - Reset asserted mid-slot takes effect immediately and returns outputs to these values.
- Slot counter:
  - cnt counts 0..CLK_DIV-1.
  - tick = (cnt==CLK_DIV-1); on tick, cnt<=0 and sel<=~sel.
- Shadow load happens on the clock edge where ld_first=1, or where tick=1 and sel=1 (frame start, the sel 1->0 switch).
  - On that edge: shadow<=hex0/hex1/dp/en, ld_first<=0, frame<=1.
  - frame=0 on all other edges.
  - Inputs are sampled only at these edges; changes mid-frame are invisible until the next frame start.
- Outputs are registered from current cnt/sel/shadow, so they lag internal state by one clock:
  - Blank window: if cnt < BLANK_CYC, com<=2'b11 and seg<=all-off.
  - Disabled digit: if shadow en[sel]=0, com<=2'b11 and seg<=all-off for the whole slot.
  - Otherwise, com<=2'b10 when sel=0 and 2'b01 when sel=1; seg<={dp_sh[sel], decode(hex_sh[sel])}.
  - SEG_INV=1 inverts all 8 seg bits, including the all-off value.
- Decode (active-high, g..a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero suppression: if LZ_BLANK=1, sel=1 and hex_sh1==0, a-g are off. Digit1 dp still follows dp_sh[1], and com still goes active when enabled.
- com is never 2'b00 under any condition.
- Period: one full frame is 2*CLK_DIV clocks, and each digit is lit for CLK_DIV-BLANK_CYC clocks per frame.

Test Plan:
Common setup: CLK_DIV=8, BLANK_CYC=2, SEG_INV=0, LZ_BLANK=1.
1. Reset and first load:
   - Stimulus: hold sys_rst=1, release with hex1=4, hex0=7, en=2'b11, dp=0.
   - Required: com=11 and seg=00 during reset; frame pulses 1 clock after release.
   - Required: after the blank window, com=10 with seg=07 for 6 clocks, then com=11 for 2 clocks, then com=01 with seg=66.
2. Tear-free update:
   - Stimulus: change hex0 to 3 while sel=1.
   - Required: digit0 keeps showing 07 until the next frame pulse, then shows 4F.
3. Leading zero and dp:
   - Stimulus: hex1=0, dp=2'b10.
   - Required: digit1 slot shows com=01 with seg=80 (dp only); with LZ_BLANK=0, seg=BF.
4. Disable:
   - Stimulus: en=2'b01.
   - Required: com stays 11 for the whole digit1 slot, and com[1] is never 0.
5. Polarity:
   - Stimulus: SEG_INV=1, hex0=8.
   - Required: seg=80 while digit0 is lit; seg=FF during blank windows and in reset.
6. Async reset mid-slot:
   - Stimulus: assert sys_rst between clock edges while com=01.
   - Required: com=11 with no clock edge; after release, the sequence restarts exactly as in scenario 1.
